// File: rtl/bc_bus_scheduler_if.sv
// Producer/consumer bundle for the B-to-C link scheduler: requester words in,
// 16-bit beats out, plus the sticky timeout flag and its clear.
interface bc_bus_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int BEAT_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      beat_valid;
  logic [BEAT_W-1:0]         beat_data;
  logic                      beat_last;
  logic                      beat_accept;
  logic                      busy;
  logic                      err_clr;
  logic                      timeout_err;

  modport master (
    output req, req_data, beat_accept, err_clr,
    input  grant, beat_valid, beat_data, beat_last, busy, timeout_err
  );

  modport slave (
    input  req, req_data, beat_accept, err_clr,
    output grant, beat_valid, beat_data, beat_last, busy, timeout_err
  );
endinterface

// File: rtl/bc_bus_scheduler.sv
// Round-robin arbiter that captures one requester's word and serializes it to
// the consumer as LSB-first beats, aborting a beat that waits too long.
module bc_bus_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int BEAT_W  = 16,
  parameter int BEATS   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clkB,
  input  logic              reset,
  bc_bus_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BEATS - 1);
  localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(NUM_REQ - 1);
  localparam logic [7:0]       TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, SEND} SchedState;

  SchedState          state, nextState;
  logic [DATA_W-1:0]  word, nextWord;
  logic [IDX_W-1:0]   idx, nextIdx;
  logic [7:0]         cnt, nextCnt;
  logic [PTR_W-1:0]   rrPtr, nextPtr;
  logic [PTR_W-1:0]   winner;
  logic               found;
  int                 cand;
  logic [NUM_REQ-1:0] nextGrant;
  logic               nextValid, nextLast, nextBusy, nextErr, setErr;
  logic [BEAT_W-1:0]  nextData;

  // rrPtr is the requester with first priority; it moves just past each winner
  always_comb begin
    nextState = state;
    nextWord  = word;
    nextIdx   = idx;
    nextCnt   = cnt;
    nextPtr   = rrPtr;
    nextGrant = '0;
    nextValid = 1'b0;
    nextBusy  = 1'b0;
    setErr    = 1'b0;
    found     = 1'b0;
    winner    = '0;
    cand      = 0;

    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rrPtr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = PTR_W'(cand);
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          nextState         = SEND;
          nextWord          = bus.req_data[int'(winner)*DATA_W +: DATA_W];
          nextIdx           = '0;
          nextCnt           = '0;
          nextPtr           = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
          nextGrant[winner] = 1'b1;
          nextValid         = 1'b1;
          nextBusy          = 1'b1;
        end
      end
      SEND: begin
        nextValid = 1'b1;
        nextBusy  = 1'b1;
        if (bus.beat_accept) begin
          if (idx == LAST_IDX) begin
            nextState = IDLE;
            nextValid = 1'b0;
            nextBusy  = 1'b0;
          end else begin
            nextIdx = idx + IDX_W'(1);
            nextCnt = '0;
          end
        end else if (cnt + 8'd1 == TIMEOUT_CNT) begin
          // Hung consumer: drop the rest of this word and flag it
          nextState = IDLE;
          nextValid = 1'b0;
          nextBusy  = 1'b0;
          nextCnt   = '0;
          setErr    = 1'b1;
        end else begin
          nextCnt = cnt + 8'd1;
        end
      end
      default: nextState = IDLE;
    endcase

    nextData = nextValid ? nextWord[int'(nextIdx)*BEAT_W +: BEAT_W] : '0;
    nextLast = nextValid && (nextIdx == LAST_IDX);
    nextErr  = setErr | (bus.timeout_err & ~bus.err_clr);
  end

  always_ff @(posedge clkB or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      word            <= '0;
      idx             <= '0;
      cnt             <= '0;
      rrPtr           <= '0;
      bus.grant       <= '0;
      bus.beat_valid  <= 1'b0;
      bus.beat_data   <= '0;
      bus.beat_last   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= nextState;
      word            <= nextWord;
      idx             <= nextIdx;
      cnt             <= nextCnt;
      rrPtr           <= nextPtr;
      bus.grant       <= nextGrant;
      bus.beat_valid  <= nextValid;
      bus.beat_data   <= nextData;
      bus.beat_last   <= nextLast;
      bus.busy        <= nextBusy;
      bus.timeout_err <= nextErr;
    end
  end
endmodule

// File: tb/tb_bc_bus_scheduler.sv
// Directed bench for bc_bus_scheduler: single word, contention, back-pressure,
// timeout, data stability and asynchronous reset mid-transfer.
module tb_bc_bus_scheduler;
  localparam logic [63:0] WORD_A = 64'h4444_3333_2222_1111;
  localparam logic [63:0] WORD_B = 64'hB004_B003_B002_B001;

  logic clkB = 1'b0;
  logic reset;
  int   vecCount = 0;
  int   errCount = 0;

  always #5 clkB = ~clkB;

  bc_bus_scheduler_if #(.NUM_REQ(2), .DATA_W(64), .BEAT_W(16)) bus ();

  bc_bus_scheduler #(
    .NUM_REQ(2), .DATA_W(64), .BEAT_W(16), .BEATS(4), .TIMEOUT(15)
  ) dut (
    .clkB  (clkB),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs, take the edge, then settle before sampling
  task automatic applyStimulus(input logic [1:0] r, input logic acc, input logic clr);
    bus.req         = r;
    bus.beat_accept = acc;
    bus.err_clr     = clr;
    @(posedge clkB);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [15:0] data, input logic last);
    checkOutput({tag, ".valid"}, 64'(bus.beat_valid), 64'd1);
    checkOutput({tag, ".data"}, 64'(bus.beat_data), 64'(data));
    checkOutput({tag, ".last"}, 64'(bus.beat_last), 64'(last));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, 64'(bus.beat_valid), 64'd0);
    checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, ".grant"}, 64'(bus.grant), 64'd0);
  endtask

  // Full word with the consumer always accepting: grant+beat0, three beats, idle
  task automatic runWord(input string tag, input logic [1:0] reqFirst,
                         input logic [1:0] reqAfter, input logic [1:0] expGrant,
                         input logic [63:0] w);
    applyStimulus(reqFirst, 1'b1, 1'b0);
    checkOutput({tag, ".grant"}, 64'(bus.grant), 64'(expGrant));
    checkOutput({tag, ".busy"}, 64'(bus.busy), 64'd1);
    checkBeat({tag, ".b0"}, w[15:0], 1'b0);
    for (int b = 1; b < 4; b++) begin
      applyStimulus(reqAfter, 1'b1, 1'b0);
      checkOutput({tag, ".grantPulse"}, 64'(bus.grant), 64'd0);
      checkOutput({tag, ".busyBeat"}, 64'(bus.busy), 64'd1);
      checkBeat({tag, ".beat"}, w[b*16 +: 16], (b == 3));
    end
    applyStimulus(reqAfter, 1'b1, 1'b0);
    checkIdle({tag, ".gap"});
  endtask

  initial begin
    reset           = 1'b0;
    bus.req         = '0;
    bus.req_data    = {WORD_B, WORD_A};
    bus.beat_accept = 1'b0;
    bus.err_clr     = 1'b0;
    #3;
    checkIdle("reset");
    checkOutput("reset.data", 64'(bus.beat_data), 64'd0);
    checkOutput("reset.err", 64'(bus.timeout_err), 64'd0);
    @(posedge clkB);
    #1;
    reset = 1'b1;

    // Single requester 0
    runWord("single", 2'b01, 2'b00, 2'b01, WORD_A);

    // Contention; requester 0 was just served so requester 1 goes first
    for (int t = 0; t < 4; t++)
      runWord("contend", 2'b11, 2'b11, (t % 2 == 0) ? 2'b10 : 2'b01,
              (t % 2 == 0) ? WORD_B : WORD_A);

    // Back-pressure: beat 1 stalled for three cycles
    applyStimulus(2'b10, 1'b1, 1'b0);
    checkOutput("bp.grant", 64'(bus.grant), 64'b10);
    checkBeat("bp.b0", 16'hB001, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("bp.b1", 16'hB002, 1'b0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkBeat("bp.hold", 16'hB002, 1'b0);
    end
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("bp.b2", 16'hB003, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("bp.b3", 16'hB004, 1'b1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkIdle("bp.end");
    checkOutput("bp.err", 64'(bus.timeout_err), 64'd0);

    // Timeout on beat 1 after fifteen stalled cycles
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("to.grant", 64'(bus.grant), 64'b01);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("to.b1", 16'h2222, 1'b0);
    for (int s = 0; s < 14; s++) begin
      applyStimulus(2'b00, 1'b0, 1'b0);
      checkBeat("to.stall", 16'h2222, 1'b0);
      checkOutput("to.errEarly", 64'(bus.timeout_err), 64'd0);
    end
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkIdle("to.abort");
    checkOutput("to.errSet", 64'(bus.timeout_err), 64'd1);
    applyStimulus(2'b10, 1'b1, 1'b0);
    checkOutput("to.regrant", 64'(bus.grant), 64'b10);
    checkBeat("to.nb0", 16'hB001, 1'b0);
    checkOutput("to.errSticky", 64'(bus.timeout_err), 64'd1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("to.nb3", 16'hB004, 1'b1);
    checkOutput("to.errHeld", 64'(bus.timeout_err), 64'd1);
    applyStimulus(2'b00, 1'b1, 1'b1);
    checkOutput("to.errClr", 64'(bus.timeout_err), 64'd0);
    checkIdle("to.end");

    // Data stability: requester 0 changes its word right after the grant
    applyStimulus(2'b01, 1'b1, 1'b0);
    checkOutput("stab.grant", 64'(bus.grant), 64'b01);
    bus.req_data[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("stab.b1", 16'h2222, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("stab.b2", 16'h3333, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("stab.b3", 16'h4444, 1'b1);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkIdle("stab.end");
    bus.req_data[63:0] = WORD_A;

    // Reset during beat 2; requester 0 was last served, so only a cleared
    // pointer lets it win first afterwards
    applyStimulus(2'b01, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkBeat("rst.b2", 16'h3333, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkIdle("rst.async");
    checkOutput("rst.data", 64'(bus.beat_data), 64'd0);
    checkOutput("rst.last", 64'(bus.beat_last), 64'd0);
    @(posedge clkB);
    #1;
    reset = 1'b1;
    runWord("rst.after", 2'b11, 2'b00, 2'b01, WORD_A);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule

// File: doc/bc_bus_scheduler.md
Name: bc_bus_scheduler

Overview:
- Arbitrates between NUM_REQ upstream 64-bit producers (device-A class sources) for the single 16-bit B-to-C link.
- Round-robin selects one requester and captures its 64-bit word.
- Serializes the word to the consumer as four 16-bit beats, least-significant first, with a valid/accept handshake per beat.
- A per-beat timeout guards against a hung consumer. Sits between the producers and device C, replacing point-to-point wiring.

Parameters:
- NUM_REQ, 2, number of upstream requesters (2..8).
- DATA_W, 64, captured word width; must equal BEATS*BEAT_W.
- BEAT_W, 16, link beat width.
- BEATS, 4, beats per word.
- TIMEOUT, 15, max cycles a beat may wait for accept before abort (1..255).

Ports:
- clkB  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req  in  NUM_REQ  per-requester ready (word available); level.
- req_data  in  NUM_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, one-cycle pulse: word captured.
- beat_valid  out  1  beat_data valid.
- beat_data  out  BEAT_W  current beat.
- beat_last  out  1  high with the final beat of a word.
- beat_accept  in  1  consumer accepts the beat when high with beat_valid at a rising edge.
- busy  out  1  transaction in progress (state != IDLE).
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky; a beat timed out.

Behaviour:
- Reset is asynchronous, active-low; clock is clkB. All outputs, state, beat index, timeout counter and word register reset to 0. RR pointer resets so requester 0 has first priority.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: beat_valid=0. If any req bit is high at edge k, select the first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping. Capture req_data of the winner and update last_grant, all at edge k. In the cycle after edge k: grant[winner]=1 for exactly one cycle, beat_valid=1, beat_data=word[BEAT_W-1:0]. Go to SEND with idx=0. Request-to-first-beat latency is 1 cycle.
  - SEND: beat_valid=1, beat_data=word[idx*BEAT_W +: BEAT_W], beat_last=(idx==BEATS-1).
    - beat_accept high at an edge with idx<BEATS-1: idx+1, timeout counter cleared.
    - beat_accept high at an edge with idx==BEATS-1: go to IDLE; beat_valid=0 for at least one cycle before the next grant.
    - beat_accept low: beat_data held stable; timeout counter +1.
    - Counter reaches TIMEOUT with no accept: abort the word, set timeout_err, go to IDLE. The remaining beats are discarded; the requester is not re-granted for this word.
- Requesters must drop req in the cycle after seeing grant, or present a new word. req still high in IDLE counts as a new request.
- req_data is sampled only at the grant edge; later changes do not affect beats in flight.
- Fairness: the granted requester gets lowest priority at the next arbitration. Any waiting requester is served within NUM_REQ transactions.
- beat_accept while beat_valid=0 is ignored.
- timeout_err is sticky until err_clr is high at an edge. If an abort and err_clr occur at the same edge, set wins.
- Reset asserted mid-transfer: immediate return to IDLE, all outputs 0, partial word discarded. The RR pointer returns to its reset value.
- No back-pressure toward producers other than grant withholding.

Test Plan:
- Single request: req=01, req_data[63:0]=0x4444_3333_2222_1111, beat_accept tied high. Next cycle grant=01; beats 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles; beat_last only on 0x4444; busy for 4 cycles.
- Contention: req=11 held continuously, words 0xA.. and 0xB... Grants alternate 01, 10, 01, 10, each followed by its 4 beats. At least one idle cycle between words. Never two grants within 5 cycles.
- Back-pressure: beat_accept low for 3 cycles on beat 1 (TIMEOUT=15). Beat 1 is held stable for 4 cycles, then beat 2 follows. timeout_err stays 0.
- Timeout: beat_accept low forever after beat 0 is accepted. After 15 stalled cycles on beat 1, beat_valid=0, timeout_err=1, state IDLE. A pending req=10 is then granted. err_clr pulse clears timeout_err.
- Reset mid-transfer: assert reset asynchronously during beat 2. All outputs go to 0 immediately. After release, req=11 grants requester 0 first.
- Data stability: change req_data of the granted requester after its grant. Beats still carry the originally captured word.
